// File: rtl/pwm_ramp_ctrl_if.sv
// pwm_ramp_ctrl_if
// Request/response bundle between a ramp requester and pwm_ramp_ctrl.
//   req      : new-target request level, held by the requester until ack
//   target   : requested final duty word (DW bits)
//   step_div : cycles-per-step minus 1 (PW bits)
//   ack      : one-cycle acceptance pulse
//   duty     : registered duty word feeding the pwm block
//   busy     : ramp in progress
//   done     : one-cycle pulse in the first cycle duty equals the target
// Modport master is the requester side, slave is the controller side.
interface pwm_ramp_ctrl_if #(
    parameter int DW = 4,
    parameter int PW = 8
);
    logic          req;
    logic [DW-1:0] target;
    logic [PW-1:0] step_div;
    logic          ack;
    logic [DW-1:0] duty;
    logic          busy;
    logic          done;

    modport master (
        output req, target, step_div,
        input  ack, duty, busy, done
    );

    modport slave (
        input  req, target, step_div,
        output ack, duty, busy, done
    );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
// Moves a registered duty word one LSB at a time toward a requested target,
// taking one step every step_div+1 clock cycles.
// Ports:
//   clk : single clock, all state changes on its rising edge
//   rst : synchronous active-high reset
//   bus : pwm_ramp_ctrl_if.slave (req/target/step_div in, ack/duty/busy/done out)
module pwm_ramp_ctrl #(
    parameter int DW = 4,
    parameter int PW = 8
) (
    input  logic             clk,
    input  logic             rst,
    pwm_ramp_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] duty_q;
    logic [DW-1:0] tgt_q;
    logic [PW-1:0] div_q;
    logic [PW-1:0] presc_q;
    logic          ack_q;
    logic          done_q;

    logic          step_hit;
    logic [DW-1:0] step_val;

    // The step value is only used in UP/DOWN, where tgt_q lies strictly
    // beyond duty_q, so neither direction can wrap.
    assign step_hit = (presc_q == div_q);
    assign step_val = (state_q == UP) ? duty_q + 1'b1 : duty_q - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Direction is decided from the live target at acceptance, which is the
    // same value being latched into tgt_q on that edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (bus.target > duty_q) begin
                        state_d = UP;
                    end else if (bus.target < duty_q) begin
                        state_d = DOWN;
                    end
                end
            end
            UP, DOWN: begin
                if (step_hit && (step_val == tgt_q)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: requests are only looked at in IDLE, so a request raised
    // during a ramp waits for the first IDLE edge without being relatched.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q  <= '0;
            tgt_q   <= '0;
            div_q   <= '0;
            presc_q <= '0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ack_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        tgt_q   <= bus.target;
                        div_q   <= bus.step_div;
                        presc_q <= '0;
                        ack_q   <= 1'b1;
                        done_q  <= (bus.target == duty_q);
                    end
                end
                UP, DOWN: begin
                    if (step_hit) begin
                        duty_q  <= step_val;
                        presc_q <= '0;
                        done_q  <= (step_val == tgt_q);
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy = (state_q == UP) || (state_q == DOWN);
        bus.ack  = ack_q;
        bus.done = done_q;
        bus.duty = duty_q;
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl
// Directed bench for pwm_ramp_ctrl. Each ramp pushes its expected per-cycle
// ack/busy/done/duty trajectory into a scoreboard queue when the request is
// driven; the records are popped and compared one per clock cycle, sampled
// 1 time unit after the rising edge.
module tb_pwm_ramp_ctrl;

    localparam int DW = 4;
    localparam int PW = 8;

    typedef struct {
        logic          ack;
        logic          busy;
        logic          done;
        logic [DW-1:0] duty;
    } exp_t;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    exp_t sb[$];

    pwm_ramp_ctrl_if #(.DW(DW), .PW(PW)) bus ();

    pwm_ramp_ctrl #(.DW(DW), .PW(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        tests_run++;
        assert (obs === exp_v) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_output(input exp_t e, input string tag);
        cmp({tag, ".ack"},  {{(DW-1){1'b0}}, bus.ack},  {{(DW-1){1'b0}}, e.ack});
        cmp({tag, ".busy"}, {{(DW-1){1'b0}}, bus.busy}, {{(DW-1){1'b0}}, e.busy});
        cmp({tag, ".done"}, {{(DW-1){1'b0}}, bus.done}, {{(DW-1){1'b0}}, e.done});
        cmp({tag, ".duty"}, bus.duty, e.duty);
    endtask

    task automatic check_idle(input string tag, input logic [DW-1:0] d);
        exp_t e;
        e.ack  = 1'b0;
        e.busy = 1'b0;
        e.done = 1'b0;
        e.duty = d;
        check_output(e, tag);
    endtask

    // Expected trajectory, counted in cycles after the acceptance edge:
    // cycle 1 carries ack, step j is visible in cycle j*(div+1)+1, and the
    // last step's cycle carries done with busy already low.
    task automatic push_ramp(input int start, input int tgt, input int div);
        int   m;
        int   n_cyc;
        int   k;
        exp_t e;
        m     = (tgt > start) ? tgt - start : start - tgt;
        n_cyc = m * (div + 1) + 1;
        for (int c = 1; c <= n_cyc; c++) begin
            k      = (c - 1) / (div + 1);
            e.ack  = (c == 1);
            e.done = (c == n_cyc);
            e.busy = (c < n_cyc);
            e.duty = DW'((tgt > start) ? start + k : start - k);
            sb.push_back(e);
        end
    endtask

    // Raise req just after an edge, let the next edge accept it, then drop
    // req and scramble target/step_div so a relatch would be visible.
    task automatic apply_stimulus(input logic [DW-1:0] t, input logic [PW-1:0] d);
        bus.req      = 1'b1;
        bus.target   = t;
        bus.step_div = d;
        @(posedge clk);
        #1;
        bus.req      = 1'b0;
        bus.target   = ~t;
        bus.step_div = 8'hA5;
    endtask

    // Pop and check up to 'limit' records (negative = all). At cycle
    // raise_at a new request is raised and left high.
    task automatic drain(input string tag, input int limit, input int raise_at,
                         input logic [DW-1:0] r_tgt, input logic [PW-1:0] r_div);
        int   c;
        exp_t e;
        c = 0;
        while (sb.size() > 0 && (limit < 0 || c < limit)) begin
            e = sb.pop_front();
            c++;
            check_output(e, $sformatf("%s.c%0d", tag, c));
            if (c == raise_at) begin
                bus.req      = 1'b1;
                bus.target   = r_tgt;
                bus.step_div = r_div;
            end
            if (sb.size() > 0 && (limit < 0 || c < limit)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle(tag, '0);
        rst = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus.req      = 1'b1;
        bus.target   = 4'd9;
        bus.step_div = 8'd0;

        // Reset held two cycles with a pending request
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_idle($sformatf("rst_hold%0d", i), '0);
        end
        rst = 1'b0;
        push_ramp(0, 9, 0);
        @(posedge clk);
        #1;
        bus.req      = 1'b0;
        bus.target   = 4'd2;
        bus.step_div = 8'hA5;
        drain("after_rst", -1, 0, '0, '0);

        pulse_reset("rst_a");

        // Up ramp 0 -> 5, one step per cycle
        push_ramp(0, 5, 0);
        apply_stimulus(4'd5, 8'd0);
        drain("up", -1, 0, '0, '0);

        // Down ramp 5 -> 2, one step every 4 cycles
        push_ramp(5, 2, 3);
        apply_stimulus(4'd2, 8'd3);
        drain("down", -1, 0, '0, '0);

        // Back-to-back up ramp 2 -> 7 with divider 1
        push_ramp(2, 7, 1);
        apply_stimulus(4'd7, 8'd1);
        drain("up2", -1, 0, '0, '0);

        // Equal target: ack and done together, never busy
        push_ramp(7, 7, 0);
        apply_stimulus(4'd7, 8'd0);
        drain("equal", -1, 0, '0, '0);
        @(posedge clk);
        #1;
        check_idle("equal_after", 4'd7);

        pulse_reset("rst_b");

        // Full-scale ramp with a request raised while busy, then 15 -> 3
        push_ramp(0, 15, 0);
        apply_stimulus(4'd15, 8'd0);
        drain("full", -1, 4, 4'd3, 8'd0);
        push_ramp(15, 3, 0);
        apply_stimulus(4'd3, 8'd0);
        drain("retgt", -1, 0, '0, '0);

        pulse_reset("rst_c");

        // Reset in the middle of a 0 -> 12 ramp once duty shows 6
        push_ramp(0, 12, 0);
        apply_stimulus(4'd12, 8'd0);
        drain("mid", 7, 0, '0, '0);
        sb.delete();
        pulse_reset("mid_rst");
        @(posedge clk);
        #1;
        check_idle("mid_after", '0);
        push_ramp(0, 4, 1);
        apply_stimulus(4'd4, 8'd1);
        drain("post_rst", -1, 0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
